word_serializer_tx: RTL and testbench
=====================================

// Module: word_serializer_tx
// PURPOSE
//   Parallel-in, serial-out framed transmitter: the read/drain end for parallel words held in the 7-bit register.
//   Accepts one WIDTH-bit word per valid/ready handshake and shifts it out on a single line as a framed bit stream.
//   Frame order: start bit (0), data LSB first, optional even parity, STOP_BITS stop bits (1).
//   Sits between the register stage and the serial link; its matching receiver is a separate block.
// PARAMETERS
//   WIDTH       7  data bits per frame (>=1)
//   BIT_CYCLES  4  clk cycles each frame bit is held on tx (>=1)
//   PARITY_EN   0  1 = append even-parity bit after data; 0 = no parity bit
//   STOP_BITS   1  number of stop bits (1 or 2)
// PORTS
//   clk      in   1      rising-edge clock
//   reset    in   1      synchronous, active-high reset
//   d        in   WIDTH  parallel word to send; sampled only on accept
//   d_valid  in   1      d holds a word to send
//   d_ready  out  1      block can accept a word this cycle
//   tx       out  1      serial line, idles high
//   busy     out  1      frame in progress
//   done     out  1      one-cycle pulse during last cycle of final stop bit
// BEHAVIOUR
//   - All outputs registered. Clock is clk; reset is synchronous and active-high: at any clk edge with reset=1,
//     state<=IDLE, tx<=1, busy<=0, d_ready<=0, done<=0, counters<=0. Reset wins over every other event.
//   - d_ready rises the first cycle after reset deasserts; then stays 1 in IDLE.
//   - Accept = d_valid & d_ready at a clk edge: latch d into shift reg, compute parity = ^d, tx<=0, busy<=1, d_ready<=0,
//     state<=START. Start bit appears on tx the cycle after the accept edge (latency 1).
//   - FSM: IDLE -> START -> DATA (WIDTH bits) -> PARITY (only if PARITY_EN) -> STOP (STOP_BITS bits) -> IDLE.
//   - Each bit held exactly BIT_CYCLES cycles; bit timer counts 0..BIT_CYCLES-1, advance on terminal count.
//   - Frame length F = BIT_CYCLES*(1+WIDTH+PARITY_EN+STOP_BITS) cycles; 7/4/0/1 -> F=36.
//   - Last cycle of final stop bit: done=1, d_ready=1, busy=1. Accept there -> next cycle tx=0 (zero-gap back-to-back);
//     no accept -> next cycle IDLE, busy=0, tx=1, done=0.
//   - d and d_valid ignored while d_ready=0; d changes mid-frame do not affect tx.
//   - Reset mid-frame: frame aborted, tx=1 next cycle, no done pulse; next accepted word sent as a full, clean frame.
//   - Widths: timer $clog2(BIT_CYCLES)+1 bits, bit index $clog2(WIDTH+1) bits; no wrap beyond terminal count.
// STRUCTURE
//   - Shared include serial_frame_defs.vh: FSM state localparams (IDLE, START, DATA, PARITY, STOP), TX_IDLE_LEVEL=1,
//     START_LEVEL=0, STOP_LEVEL=1; reused by the matching receiver.
//   - One sub-module: bit_timer (params BIT_CYCLES; in clk, reset, run; out tick on terminal count).
//   - Top holds FSM, shift register, parity, bit/stop counters, handshake regs.
// TESTING  (default params unless stated)
//   1 Hold reset 2 cycles with d_valid=1 -> tx=1, busy=0, d_ready=0, done=0; d_ready=1 one cycle after release.
//   2 Accept d=7'b0000111 -> tx = 0,1,1,1,0,0,0,0,1 each held 4 cycles; done pulses once on cycle 36 after accept.
//   3 PARITY_EN=1: d=7'b1010101 -> parity bit 0; d=7'b0000111 -> parity bit 1; frame 40 cycles.
//   4 d_valid held, d=7'h55 then 7'h2A -> second start bit directly follows stop; 72 cycles total, two done pulses.
//   5 reset=1 during data bit 3 of 7'h7F -> tx=1, busy=0 next cycle, no done; then 7'h01 sent correctly.
//   6 Change d and toggle d_valid while busy -> no accept, transmitted bits match word latched at accept.

Source files
------------

// File: rtl/word_serializer_tx_pkg.sv
// Shared definitions for the framed serial link (transmitter and its receiver).
//   tx_state_e     : frame FSM states
//   *_LEVEL        : line levels for idle, start and stop bits
package word_serializer_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } tx_state_e;

  localparam logic TX_IDLE_LEVEL = 1'b1;
  localparam logic START_LEVEL   = 1'b0;
  localparam logic STOP_LEVEL    = 1'b1;

endpackage

// File: rtl/word_serializer_tx_if.sv
// Parallel word handshake into the serializer.
//   d       : word to send, sampled only on accept
//   d_valid : source has a word
//   d_ready : serializer can take a word this cycle
interface word_serializer_tx_if #(
  parameter int WIDTH = 7
);
  logic [WIDTH-1:0] d;
  logic             d_valid;
  logic             d_ready;

  modport master (output d, output d_valid, input d_ready);
  modport slave  (input d, input d_valid, output d_ready);
endinterface

// File: rtl/word_serializer_tx_bit_timer.sv
// Bit period timer: counts 0..BIT_CYCLES-1 while run is high, wraps on
// terminal count and holds at 0 while stopped.
//   clk, reset : clock, synchronous active-high reset
//   run        : count enable (frame in progress)
//   tick       : current cycle is the last cycle of the bit
//   tick_next  : next cycle will be the last cycle of a bit (if run holds)
module bit_timer #(
  parameter int BIT_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic run,
  output logic tick,
  output logic tick_next
);
  localparam int CNT_W = $clog2(BIT_CYCLES) + 1;
  localparam logic [CNT_W-1:0] TERM = CNT_W'(BIT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign cnt_d     = (cnt_q == TERM) ? '0 : cnt_q + CNT_W'(1);
  assign tick      = run && (cnt_q == TERM);
  // lookahead lets the top register done/d_ready for the final cycle
  assign tick_next = (cnt_d == TERM);

  always_ff @(posedge clk) begin
    if (reset || !run) cnt_q <= '0;
    else               cnt_q <= cnt_d;
  end
endmodule

// File: rtl/word_serializer_tx.sv
// Framed parallel-to-serial transmitter.
// Frame: start (0), WIDTH data bits LSB first, optional even parity,
// STOP_BITS stop bits (1). Each bit lasts BIT_CYCLES clocks.
//   clk, reset : clock, synchronous active-high reset
//   in_if      : d / d_valid / d_ready word handshake (slave side)
//   tx         : serial line, idles high
//   busy       : frame in progress
//   done       : high during the last cycle of the final stop bit
module word_serializer_tx
  import word_serializer_tx_pkg::*;
#(
  parameter int WIDTH      = 7,
  parameter int BIT_CYCLES = 4,
  parameter int PARITY_EN  = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                clk,
  input  logic                reset,
  word_serializer_tx_if.slave in_if,
  output logic                tx,
  output logic                busy,
  output logic                done
);
  localparam int BIDX_W = $clog2(WIDTH + 1);
  localparam logic [BIDX_W-1:0] LAST_BIT  = BIDX_W'(WIDTH - 1);
  localparam logic [1:0]        LAST_STOP = 2'(STOP_BITS - 1);

  tx_state_e         state_q;
  logic [WIDTH-1:0]  sh_q;
  logic              par_q;
  logic [BIDX_W-1:0] bit_q;
  logic [1:0]        stop_q;
  logic              tx_q, busy_q, d_ready_q, done_q;

  logic tick, tick_next, accept, last_stop_d, done_d, stop_end;

  bit_timer #(.BIT_CYCLES(BIT_CYCLES)) u_timer (
    .clk       (clk),
    .reset     (reset),
    .run       (state_q != ST_IDLE),
    .tick      (tick),
    .tick_next (tick_next)
  );

  assign accept   = in_if.d_valid && d_ready_q;
  assign stop_end = (state_q == ST_STOP) && tick && (stop_q == LAST_STOP);

  // Will the next cycle be inside the final stop bit?
  always_comb begin
    last_stop_d = 1'b0;
    case (state_q)
      ST_DATA:   last_stop_d = tick && (bit_q == LAST_BIT) &&
                               (PARITY_EN == 0) && (STOP_BITS == 1);
      ST_PARITY: last_stop_d = tick && (STOP_BITS == 1);
      ST_STOP:   last_stop_d = tick ? (2'(stop_q + 2'd1) == LAST_STOP)
                                    : (stop_q == LAST_STOP);
      default:   last_stop_d = 1'b0;
    endcase
  end

  assign done_d = last_stop_d && tick_next;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      sh_q      <= '0;
      par_q     <= 1'b0;
      bit_q     <= '0;
      stop_q    <= '0;
      tx_q      <= TX_IDLE_LEVEL;
      busy_q    <= 1'b0;
      d_ready_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= done_d;
      // accept only happens in IDLE or the final stop cycle
      if (accept) begin
        state_q   <= ST_START;
        sh_q      <= in_if.d;
        par_q     <= ^in_if.d;
        bit_q     <= '0;
        stop_q    <= '0;
        tx_q      <= START_LEVEL;
        busy_q    <= 1'b1;
        d_ready_q <= 1'b0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            d_ready_q <= 1'b1;
            busy_q    <= 1'b0;
            tx_q      <= TX_IDLE_LEVEL;
          end
          ST_START: if (tick) begin
            state_q <= ST_DATA;
            tx_q    <= sh_q[0];
            sh_q    <= sh_q >> 1;
          end
          ST_DATA: if (tick) begin
            if (bit_q == LAST_BIT) begin
              if (PARITY_EN != 0) begin
                state_q <= ST_PARITY;
                tx_q    <= par_q;
              end else begin
                state_q <= ST_STOP;
                tx_q    <= STOP_LEVEL;
              end
            end else begin
              bit_q <= bit_q + BIDX_W'(1);
              tx_q  <= sh_q[0];
              sh_q  <= sh_q >> 1;
            end
          end
          ST_PARITY: if (tick) begin
            state_q <= ST_STOP;
            tx_q    <= STOP_LEVEL;
          end
          ST_STOP: if (tick) begin
            if (stop_q == LAST_STOP) begin
              state_q <= ST_IDLE;
              busy_q  <= 1'b0;
              tx_q    <= TX_IDLE_LEVEL;
            end else begin
              stop_q <= stop_q + 2'd1;
            end
          end
          default: state_q <= ST_IDLE;
        endcase
        // ready opens for the final stop cycle and stays open into IDLE
        if (state_q != ST_IDLE) d_ready_q <= done_d || stop_end;
      end
    end
  end

  assign in_if.d_ready = d_ready_q;
  assign tx            = tx_q;
  assign busy          = busy_q;
  assign done          = done_q;
endmodule

// File: tb/tb_word_serializer_tx.sv
module tb_word_serializer_tx;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  word_serializer_tx_if #(.WIDTH(7)) if0 ();
  word_serializer_tx_if #(.WIDTH(7)) if1 ();
  logic tx0, busy0, done0, tx1, busy1, done1;

  word_serializer_tx #(.WIDTH(7), .BIT_CYCLES(4), .PARITY_EN(0), .STOP_BITS(1)) dut0 (
    .clk(clk), .reset(reset), .in_if(if0.slave), .tx(tx0), .busy(busy0), .done(done0));
  word_serializer_tx #(.WIDTH(7), .BIT_CYCLES(4), .PARITY_EN(1), .STOP_BITS(1)) dut1 (
    .clk(clk), .reset(reset), .in_if(if1.slave), .tx(tx1), .busy(busy1), .done(done1));

  int checks = 0;
  int errors = 0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // expected line level for frame bit idx (0 = start)
  function automatic logic exp_bit(logic [6:0] w, bit par, int idx);
    if (idx == 0) return 1'b0;
    if (idx <= 7) return w[idx-1];
    if (par && idx == 8) return ^w;
    return 1'b1;
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    if0.d = 7'h55; if0.d_valid = 1'b1;
    if1.d = 7'h55; if1.d_valid = 1'b1;
    step(); step();
    checks++; if (tx0 !== 1'b1) begin errors++; $display("FAIL reset_tx: got %b want 1", tx0); end
    checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy0); end
    checks++; if (if0.d_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b want 0", if0.d_ready); end
    checks++; if (done0 !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done0); end
    checks++; if (tx1 !== 1'b1) begin errors++; $display("FAIL reset_tx_par: got %b want 1", tx1); end
    reset = 1'b0;
    if0.d_valid = 1'b0;
    if1.d_valid = 1'b0;
    step();
    checks++; if (if0.d_ready !== 1'b1) begin errors++; $display("FAIL ready_after_reset: got %b want 1", if0.d_ready); end
    checks++; if (if1.d_ready !== 1'b1) begin errors++; $display("FAIL ready_after_reset_par: got %b want 1", if1.d_ready); end
    checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL busy_after_reset: got %b want 0", busy0); end
  endtask

  task automatic test_basic();
    logic [6:0] w;
    w = 7'b0000111;
    if0.d = w; if0.d_valid = 1'b1;
    step();
    if0.d_valid = 1'b0;
    for (int k = 0; k < 36; k++) begin
      checks++; if (tx0 !== exp_bit(w, 1'b0, k/4)) begin errors++; $display("FAIL basic_tx k=%0d: got %b want %b", k, tx0, exp_bit(w, 1'b0, k/4)); end
      checks++; if (done0 !== (k == 35)) begin errors++; $display("FAIL basic_done k=%0d: got %b want %b", k, done0, (k == 35)); end
      checks++; if (busy0 !== 1'b1) begin errors++; $display("FAIL basic_busy k=%0d: got %b want 1", k, busy0); end
      checks++; if (if0.d_ready !== (k == 35)) begin errors++; $display("FAIL basic_ready k=%0d: got %b want %b", k, if0.d_ready, (k == 35)); end
      step();
    end
    checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL basic_idle_busy: got %b want 0", busy0); end
    checks++; if (tx0 !== 1'b1) begin errors++; $display("FAIL basic_idle_tx: got %b want 1", tx0); end
    checks++; if (done0 !== 1'b0) begin errors++; $display("FAIL basic_idle_done: got %b want 0", done0); end
    checks++; if (if0.d_ready !== 1'b1) begin errors++; $display("FAIL basic_idle_ready: got %b want 1", if0.d_ready); end
  endtask

  task automatic test_parity();
    logic [6:0] ws [2];
    logic       pexp [2];
    ws[0] = 7'b1010101; pexp[0] = 1'b0;
    ws[1] = 7'b0000111; pexp[1] = 1'b1;
    for (int i = 0; i < 2; i++) begin
      if1.d = ws[i]; if1.d_valid = 1'b1;
      step();
      if1.d_valid = 1'b0;
      for (int k = 0; k < 40; k++) begin
        checks++; if (tx1 !== exp_bit(ws[i], 1'b1, k/4)) begin errors++; $display("FAIL parity_tx w=%0d k=%0d: got %b want %b", i, k, tx1, exp_bit(ws[i], 1'b1, k/4)); end
        checks++; if (done1 !== (k == 39)) begin errors++; $display("FAIL parity_done w=%0d k=%0d: got %b want %b", i, k, done1, (k == 39)); end
        if (k == 33) begin
          checks++; if (tx1 !== pexp[i]) begin errors++; $display("FAIL parity_bit w=%0d: got %b want %b", i, tx1, pexp[i]); end
        end
        step();
      end
      checks++; if (busy1 !== 1'b0) begin errors++; $display("FAIL parity_idle w=%0d: got %b want 0", i, busy1); end
    end
  endtask

  task automatic test_back_to_back();
    logic [6:0] w;
    int ndone;
    ndone = 0;
    if0.d = 7'h55; if0.d_valid = 1'b1;
    step();
    for (int k = 0; k < 72; k++) begin
      w = (k < 36) ? 7'h55 : 7'h2A;
      checks++; if (tx0 !== exp_bit(w, 1'b0, (k % 36)/4)) begin errors++; $display("FAIL b2b_tx k=%0d: got %b want %b", k, tx0, exp_bit(w, 1'b0, (k % 36)/4)); end
      checks++; if (done0 !== (k == 35 || k == 71)) begin errors++; $display("FAIL b2b_done k=%0d: got %b want %b", k, done0, (k == 35 || k == 71)); end
      checks++; if (busy0 !== 1'b1) begin errors++; $display("FAIL b2b_busy k=%0d: got %b want 1", k, busy0); end
      if (done0 === 1'b1) ndone++;
      if (k == 35) if0.d = 7'h2A;
      if (k == 36) if0.d_valid = 1'b0;
      step();
    end
    checks++; if (ndone !== 2) begin errors++; $display("FAIL b2b_done_count: got %0d want 2", ndone); end
    checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL b2b_idle: got %b want 0", busy0); end
  endtask

  task automatic test_reset_mid();
    if0.d = 7'h7F; if0.d_valid = 1'b1;
    step();
    if0.d_valid = 1'b0;
    for (int k = 0; k < 18; k++) begin
      checks++; if (tx0 !== exp_bit(7'h7F, 1'b0, k/4)) begin errors++; $display("FAIL abort_tx k=%0d: got %b want %b", k, tx0, exp_bit(7'h7F, 1'b0, k/4)); end
      checks++; if (done0 !== 1'b0) begin errors++; $display("FAIL abort_done k=%0d: got %b want 0", k, done0); end
      step();
    end
    reset = 1'b1;
    step();
    checks++; if (tx0 !== 1'b1) begin errors++; $display("FAIL abort_tx_after: got %b want 1", tx0); end
    checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL abort_busy_after: got %b want 0", busy0); end
    checks++; if (done0 !== 1'b0) begin errors++; $display("FAIL abort_done_after: got %b want 0", done0); end
    reset = 1'b0;
    step();
    checks++; if (if0.d_ready !== 1'b1) begin errors++; $display("FAIL abort_ready: got %b want 1", if0.d_ready); end
    if0.d = 7'h01; if0.d_valid = 1'b1;
    step();
    if0.d_valid = 1'b0;
    for (int k = 0; k < 36; k++) begin
      checks++; if (tx0 !== exp_bit(7'h01, 1'b0, k/4)) begin errors++; $display("FAIL post_abort_tx k=%0d: got %b want %b", k, tx0, exp_bit(7'h01, 1'b0, k/4)); end
      checks++; if (done0 !== (k == 35)) begin errors++; $display("FAIL post_abort_done k=%0d: got %b want %b", k, done0, (k == 35)); end
      step();
    end
    checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL post_abort_idle: got %b want 0", busy0); end
  endtask

  task automatic test_ignore_busy();
    logic [6:0] w;
    w = 7'b1011001;
    if0.d = w; if0.d_valid = 1'b1;
    step();
    for (int k = 0; k < 36; k++) begin
      checks++; if (tx0 !== exp_bit(w, 1'b0, k/4)) begin errors++; $display("FAIL ignore_tx k=%0d: got %b want %b", k, tx0, exp_bit(w, 1'b0, k/4)); end
      checks++; if (if0.d_ready !== (k == 35)) begin errors++; $display("FAIL ignore_ready k=%0d: got %b want %b", k, if0.d_ready, (k == 35)); end
      checks++; if (done0 !== (k == 35)) begin errors++; $display("FAIL ignore_done k=%0d: got %b want %b", k, done0, (k == 35)); end
      if (k < 34) begin
        if0.d = 7'($urandom);
        if0.d_valid = (k % 2 == 1);
      end else begin
        if0.d_valid = 1'b0;
      end
      step();
    end
    checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL ignore_idle_busy: got %b want 0", busy0); end
    checks++; if (tx0 !== 1'b1) begin errors++; $display("FAIL ignore_idle_tx: got %b want 1", tx0); end
  endtask

  initial begin
    if0.d = '0; if0.d_valid = 1'b0;
    if1.d = '0; if1.d_valid = 1'b0;
    test_reset();
    test_basic();
    test_parity();
    test_back_to_back();
    test_reset_mid();
    test_ignore_busy();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
